debug_dump_sequencer: RTL and testbench

//  Debug-side sequencer that walks the MIPS state after halt/step and streams it over the UART.

---
 rtl/debug_dump_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer
//
// Walks the MIPS debug state after halt/step and streams it to the UART:
// first the PC, then CANT_REGS register words, then CANT_MEM_DATOS data-memory
// words. Each LEN-bit word goes out as LEN/LEN_DATA bytes, MSB first.
//
// Ports
//   clk                in   system clock (shared with recolector and uart)
//   reset              in   asynchronous, active-low reset
//   start              in   one-cycle dump request, sampled only in IDLE
//   abort              in   cancels a dump in progress (no done pulse)
//   pc                 in   MIPS PC, captured when start is accepted
//   recolector_data    in   word currently selected by the recolector
//   tx_done            in   uart byte-transmitted tick
//   restart_recolector out  pulse: recolector address back to 0
//   send_regs          out  level: 1 = recolector selects registers, 0 = memory
//   enable_next        out  pulse: recolector address +1
//   tx_start           out  pulse: uart starts sending uart_data_out
//   uart_data_out      out  byte to transmit, stable from tx_start until tx_done
//   busy               out  1 whenever the sequencer is not IDLE
//   done               out  pulse after the last byte's tx_done
//   state_dbg          out  current FSM state encoding, for debug visibility
//
// UART handshake: tx_start is a one-cycle request that hands the byte on
// uart_data_out to the uart; the byte is held unchanged until the uart
// answers with a one-cycle tx_done. Only one byte is ever outstanding, and
// tx_done is only acted upon while waiting for it (WAIT_TX); a tick arriving
// in any other state is ignored.
module debug_dump_sequencer #(
    parameter int LEN            = 32,
    parameter int LEN_DATA       = 8,
    parameter int CANT_REGS      = 32,
    parameter int CANT_MEM_DATOS = 16,
    parameter int FETCH_WAIT     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [LEN-1:0]      pc,
    input  logic [LEN-1:0]      recolector_data,
    input  logic                tx_done,
    output logic                restart_recolector,
    output logic                send_regs,
    output logic                enable_next,
    output logic                tx_start,
    output logic [LEN_DATA-1:0] uart_data_out,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);

    localparam int BYTES = LEN / LEN_DATA;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MAXW  = (CANT_REGS > CANT_MEM_DATOS) ? CANT_REGS : CANT_MEM_DATOS;
    localparam int WW    = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int FWW   = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;

    localparam logic [BW-1:0]  LAST_BYTE  = BW'(BYTES - 1);
    localparam logic [WW-1:0]  LAST_REG   = WW'(CANT_REGS - 1);
    localparam logic [WW-1:0]  LAST_MEM   = WW'(CANT_MEM_DATOS - 1);
    localparam logic [FWW-1:0] LAST_FETCH = FWW'(FETCH_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT_TX = 3'd2,
        S_ADVANCE = 3'd3,
        S_FETCH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC   = 2'd0,
        SEC_REGS = 2'd1,
        SEC_MEM  = 2'd2
    } section_t;

    state_t         state;
    state_t         state_nxt;
    section_t       section;
    logic [LEN-1:0] word_reg;
    logic [BW-1:0]  byte_cnt;
    logic [WW-1:0]  word_cnt;
    logic [FWW-1:0] fetch_cnt;

    // Decoded position inside the dump, shared by next-state and output logic.
    logic last_byte;
    logic last_reg_word;
    logic last_mem_word;

    assign last_byte     = (byte_cnt == LAST_BYTE);
    assign last_reg_word = (word_cnt == LAST_REG);
    assign last_mem_word = (word_cnt == LAST_MEM);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. abort has priority over everything, including a
    // simultaneous start in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    state_nxt = S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        state_nxt = last_byte ? S_ADVANCE : S_SEND;
                    end
                end
                S_ADVANCE: begin
                    if (section == SEC_MEM && last_mem_word) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_cnt == LAST_FETCH) begin
                        state_nxt = S_SEND;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: word shift register, counters, section and send_regs level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_reg  <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            fetch_cnt <= '0;
            section   <= SEC_PC;
            send_regs <= 1'b0;
        end else if (abort) begin
            send_regs <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_reg <= pc;
                        section  <= SEC_PC;
                        byte_cnt <= '0;
                    end
                end
                S_WAIT_TX: begin
                    // The byte on the wire is always the top slice of word_reg,
                    // so moving to the next byte is a left shift.
                    if (tx_done && !last_byte) begin
                        word_reg <= word_reg << LEN_DATA;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    fetch_cnt <= '0;
                    case (section)
                        SEC_PC: begin
                            section   <= SEC_REGS;
                            send_regs <= 1'b1;
                            word_cnt  <= '0;
                        end
                        SEC_REGS: begin
                            if (last_reg_word) begin
                                section   <= SEC_MEM;
                                send_regs <= 1'b0;
                                word_cnt  <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end
                        SEC_MEM: begin
                            if (!last_mem_word) begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end
                        default: begin
                            section <= SEC_PC;
                        end
                    endcase
                end
                S_FETCH: begin
                    // recolector_data is only trusted on the final wait cycle.
                    if (fetch_cnt == LAST_FETCH) begin
                        word_reg <= recolector_data;
                        byte_cnt <= '0;
                    end else begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    send_regs <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. All are decoded from registered state, so an asynchronous
    // reset drives them to 0 immediately.
    // ------------------------------------------------------------------
    always_comb begin
        tx_start           = 1'b0;
        restart_recolector = 1'b0;
        enable_next        = 1'b0;
        done               = 1'b0;
        uart_data_out      = '0;
        busy               = (state != S_IDLE);
        state_dbg          = state;
        case (state)
            S_SEND: begin
                tx_start      = 1'b1;
                uart_data_out = word_reg[LEN-1 -: LEN_DATA];
            end
            S_WAIT_TX: begin
                uart_data_out = word_reg[LEN-1 -: LEN_DATA];
            end
            S_ADVANCE: begin
                // Section changes rewind the recolector; words within a
                // section step it forward. The final memory word does neither.
                if (section == SEC_PC) begin
                    restart_recolector = 1'b1;
                end else if (section == SEC_REGS) begin
                    if (last_reg_word) begin
                        restart_recolector = 1'b1;
                    end else begin
                        enable_next = 1'b1;
                    end
                end else if (section == SEC_MEM) begin
                    if (!last_mem_word) begin
                        enable_next = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
`timescale 1ns/1ps
module tb_debug_dump_sequencer;

  localparam int NREG   = 32;
  localparam int NMEM   = 16;
  localparam int FW     = 2;
  localparam int NBYTES = 4 * (1 + NREG + NMEM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] pc;
  logic [31:0] rec_data;
  logic        tx_done;
  logic        restart_recolector;
  logic        send_regs;
  logic        enable_next;
  logic        tx_start;
  logic [7:0]  uart_data_out;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  debug_dump_sequencer #(
    .LEN(32), .LEN_DATA(8), .CANT_REGS(NREG), .CANT_MEM_DATOS(NMEM), .FETCH_WAIT(FW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pc(pc),
    .recolector_data(rec_data), .tx_done(tx_done),
    .restart_recolector(restart_recolector), .send_regs(send_regs),
    .enable_next(enable_next), .tx_start(tx_start), .uart_data_out(uart_data_out),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Minimal build: one register word, one memory word.
  logic        start_s;
  logic        abort_s;
  logic [31:0] pc_s;
  logic [31:0] rec_data_s;
  logic        tx_done_s;
  logic        restart_s;
  logic        send_regs_s;
  logic        enable_s;
  logic        tx_start_s;
  logic [7:0]  uart_s;
  logic        busy_s;
  logic        done_s;
  logic [2:0]  state_dbg_s;

  debug_dump_sequencer #(
    .LEN(32), .LEN_DATA(8), .CANT_REGS(1), .CANT_MEM_DATOS(1), .FETCH_WAIT(FW)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .pc(pc_s),
    .recolector_data(rec_data_s), .tx_done(tx_done_s),
    .restart_recolector(restart_s), .send_regs(send_regs_s),
    .enable_next(enable_s), .tx_start(tx_start_s), .uart_data_out(uart_s),
    .busy(busy_s), .done(done_s), .state_dbg(state_dbg_s)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       sr_q[$];

  int tx_cnt, restart_cnt, enable_cnt, done_cnt, unstable_cnt, busy_after_done_cnt;

  // environment model state
  logic [31:0] pc_val = 32'h0;
  bit          spurious_mode = 1'b0;
  int          cd;
  bit          outstanding;
  logic [7:0]  cur_byte;
  bit          prev_done;
  int          rsec;
  int          raddr;
  int          age;

  // Expected byte stream straight from the dump rules: pc, reg[i]=i, mem[j]=0x100+j.
  function automatic void build_exp(input logic [31:0] p);
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < 1 + NREG + NMEM; k++) begin
      if (k == 0) w = p;
      else if (k <= NREG) w = 32'(k - 1);
      else w = 32'h100 + 32'(k - 1 - NREG);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31 - 8*b -: 8]);
    end
  endfunction

  // ---------------- environment: uart + recolector models, monitor ----------------
  initial begin
    tx_done  = 1'b0;
    rec_data = 32'h0;
    pc       = 32'h0;
    cd = 0; outstanding = 0; cur_byte = 8'h0; prev_done = 0;
    rsec = 0; raddr = 0; age = 99;
    forever begin
      @(posedge clk); #1;
      if (reset !== 1'b1) begin
        cd = 0; outstanding = 0; tx_done = 1'b0; prev_done = 0;
        rsec = 0; raddr = 0; age = 99; pc = pc_val;
      end else begin
        // monitor
        if (restart_recolector) restart_cnt++;
        if (enable_next) enable_cnt++;
        if (prev_done && busy) busy_after_done_cnt++;
        prev_done = done;
        if (done) done_cnt++;
        if (outstanding && busy && uart_data_out !== cur_byte) unstable_cnt++;
        // uart model
        tx_done = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            tx_done = 1'b1;
            outstanding = 0;
          end
        end else if (spurious_mode && !outstanding && $urandom_range(0, 3) == 0) begin
          tx_done = 1'b1;
        end
        if (tx_start) begin
          got_q.push_back(uart_data_out);
          sr_q.push_back(send_regs);
          tx_cnt++;
          cur_byte = uart_data_out;
          outstanding = 1;
          cd = spurious_mode ? $urandom_range(1, 50) : 3;
        end
        // recolector model: data valid FW cycles after restart/enable_next
        if (!busy) begin
          rsec = 0; raddr = 0; age = 99;
        end
        if (restart_recolector) begin
          raddr = 0; age = 0; rsec = (rsec == 1) ? 2 : 1;
        end else if (enable_next) begin
          raddr++; age = 0;
        end else if (age < 99) begin
          age++;
        end
        if (age >= FW) rec_data = (rsec == 1) ? 32'(raddr) : 32'h100 + 32'(raddr);
        else rec_data = $urandom;
        // pc only matters on the start edge; scramble it otherwise
        pc = busy ? $urandom : pc_val;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_monitor();
    got_q.delete();
    sr_q.delete();
    tx_cnt = 0; restart_cnt = 0; enable_cnt = 0; done_cnt = 0;
    unstable_cnt = 0; busy_after_done_cnt = 0;
  endtask

  // Returns at the negedge of the cycle after the start edge.
  task automatic do_start();
    @(negedge clk);
    clear_monitor();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet();
    for (int c = 0; c < 200 && outstanding; c++) @(posedge clk);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; pc_s = 32'h0; rec_data_s = 32'h0; tx_done_s = 1'b0;
    clear_monitor();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({tx_start, busy, done, send_regs, restart_recolector, enable_next, uart_data_out} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got tx_start=%b busy=%b done=%b send_regs=%b restart=%b enable=%b data=%h want all 0",
               tx_start, busy, done, send_regs, restart_recolector, enable_next, uart_data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full();
    bit ok;
    spurious_mode = 0;
    pc_val = 32'h0000_0040;
    build_exp(pc_val);
    do_start();
    checks++;
    if (tx_start !== 1'b1 || uart_data_out !== 8'h00) begin
      errors++;
      $display("FAIL full_latency got tx_start=%b data=%h want 1 00", tx_start, uart_data_out);
    end
    wait_done(20000, ok);
    checks++;
    if (!ok || done_cnt !== 1) begin
      errors++;
      $display("FAIL full_done got done_cnt=%0d want 1", done_cnt);
    end
    checks++;
    if (tx_cnt !== NBYTES) begin
      errors++;
      $display("FAIL full_bytes got %0d want %0d", tx_cnt, NBYTES);
    end
    for (int i = 0; i < NBYTES && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
      checks++;
      if (sr_q[i] !== ((i >= 4 && i < 4 + 4*NREG) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL full_send_regs[%0d] got %b want %b", i, sr_q[i], (i >= 4 && i < 4 + 4*NREG));
      end
    end
    checks++;
    if (got_q.size() > 131 && (got_q[128] !== 8'h00 || got_q[131] !== 8'h1F)) begin
      errors++;
      $display("FAIL full_last_reg got %h..%h want 00..1f", got_q[128], got_q[131]);
    end
    checks++;
    if (restart_cnt !== 2 || enable_cnt !== NREG - 1 + NMEM - 1) begin
      errors++;
      $display("FAIL full_recolector got restart=%0d enable=%0d want 2 %0d", restart_cnt, enable_cnt, NREG + NMEM - 2);
    end
    checks++;
    if (unstable_cnt !== 0 || busy_after_done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_hold got unstable=%0d busy_after_done=%0d busy=%b want 0 0 0", unstable_cnt, busy_after_done_cnt, busy);
    end
  endtask

  task automatic test_random_tx();
    bit ok;
    spurious_mode = 1;
    pc_val = 32'h0000_0040;
    build_exp(pc_val);
    do_start();
    wait_done(30000, ok);
    checks++;
    if (!ok || done_cnt !== 1 || tx_cnt !== NBYTES) begin
      errors++;
      $display("FAIL random_count got done=%0d bytes=%0d want 1 %0d", done_cnt, tx_cnt, NBYTES);
    end
    for (int i = 0; i < NBYTES && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (restart_cnt !== 2 || enable_cnt !== NREG + NMEM - 2 || unstable_cnt !== 0) begin
      errors++;
      $display("FAIL random_handshake got restart=%0d enable=%0d unstable=%0d want 2 %0d 0",
               restart_cnt, enable_cnt, unstable_cnt, NREG + NMEM - 2);
    end
    spurious_mode = 0;
    wait_quiet();
  endtask

  task automatic test_restart_ignored();
    bit ok;
    pc_val = $urandom;
    build_exp(pc_val);
    do_start();
    for (int c = 0; c < 5000 && tx_cnt < 40; c++) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20000, ok);
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (!ok || done_cnt !== 1 || tx_cnt !== NBYTES || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignored got done=%0d bytes=%0d busy=%b want 1 %0d 0", done_cnt, tx_cnt, busy, NBYTES);
    end
    for (int i = 0; i < NBYTES && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    pc_val = $urandom;
    do_start();
    for (int c = 0; c < 5000 && tx_cnt < 10; c++) begin
      @(posedge clk); #2;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || send_regs !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b send_regs=%b tx_start=%b want 0 0 0", busy, send_regs, tx_start);
    end
    repeat (60) @(posedge clk);
    #2;
    checks++;
    if (tx_cnt !== 10 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_quiet got bytes=%0d done=%0d want 10 0", tx_cnt, done_cnt);
    end
    wait_quiet();
    pc_val = 32'h0000_0040;
    build_exp(pc_val);
    do_start();
    wait_done(20000, ok);
    checks++;
    if (!ok || done_cnt !== 1 || tx_cnt !== NBYTES) begin
      errors++;
      $display("FAIL abort_redump got done=%0d bytes=%0d want 1 %0d", done_cnt, tx_cnt, NBYTES);
    end
    for (int i = 0; i < NBYTES && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_byte[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    pc_val = 32'h0000_0040;
    do_start();
    for (int c = 0; c < 5000 && !(tx_cnt >= 150 && tx_cnt % 4 == 3); c++) begin
      @(posedge clk); #2;
    end
    @(negedge clk);
    #1;
    // byte 2 of a memory word 0x000001xx is 0x01
    checks++;
    if (busy !== 1'b1 || uart_data_out !== 8'h01 || send_regs !== 1'b0) begin
      errors++;
      $display("FAIL mem_pre_reset got busy=%b data=%h send_regs=%b want 1 01 0", busy, uart_data_out, send_regs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || uart_data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_busy_data got busy=%b data=%h want 0 00", busy, uart_data_out);
    end
    checks++;
    if ({tx_start, done, send_regs, restart_recolector, enable_next} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_pulses got %b want 00000",
               {tx_start, done, send_regs, restart_recolector, enable_next});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got done=%0d busy=%b want 0 0", done_cnt, busy);
    end
  endtask

  task automatic test_small_build();
    logic [7:0] got_s[$];
    logic [7:0] exp_s[$];
    logic [31:0] w;
    int n_restart = 0, n_enable = 0, n_done = 0;
    int scd = 0, ssec = 0, saddr = 0, sage = 99;
    pc_s = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? pc_s : (k == 1) ? 32'h0 : 32'h100;
      for (int b = 0; b < 4; b++) exp_s.push_back(w[31 - 8*b -: 8]);
    end
    @(negedge clk);
    start_s = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
      if (restart_s) n_restart++;
      if (enable_s) n_enable++;
      if (done_s) n_done++;
      tx_done_s = 1'b0;
      if (scd > 0) begin
        scd--;
        if (scd == 0) tx_done_s = 1'b1;
      end
      if (tx_start_s) begin
        got_s.push_back(uart_s);
        scd = 2;
      end
      if (restart_s) begin
        saddr = 0; sage = 0; ssec = (ssec == 1) ? 2 : 1;
      end else if (enable_s) begin
        saddr++; sage = 0;
      end else if (sage < 99) begin
        sage++;
      end
      if (sage >= FW) rec_data_s = (ssec == 1) ? 32'(saddr) : 32'h100 + 32'(saddr);
      else rec_data_s = $urandom;
    end
    checks++;
    if (got_s.size() !== 12 || n_done !== 1) begin
      errors++;
      $display("FAIL small_count got bytes=%0d done=%0d want 12 1", got_s.size(), n_done);
    end
    checks++;
    if (n_restart !== 2 || n_enable !== 0) begin
      errors++;
      $display("FAIL small_recolector got restart=%0d enable=%0d want 2 0", n_restart, n_enable);
    end
    for (int i = 0; i < 12 && i < got_s.size(); i++) begin
      checks++;
      if (got_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL small_byte[%0d] got %h want %h", i, got_s[i], exp_s[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full();
    test_random_tx();
    test_restart_ignored();
    test_abort();
    test_reset_mid_mem();
    test_small_build();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
